decode_stage_nway: RTL and testbench
====================================

Name: decode_stage_nway

Overview:
- Parametrised successor to the single-way decoder: decodes a bundle of WAYS instructions per cycle and holds the results in an output pipeline register with a valid/ready handshake.
- Detects read-after-write dependences inside a bundle and splits the bundle over several cycles.
- Sits between the IFU (upstream handshake) and the DU/issue register (downstream handshake). Register-file reads happen downstream, using the rs addresses and enables it outputs.

Parameters:
- WAYS, 2, instructions per bundle (1..4).
- XLEN, 64, immediate width; all immediates are sign-extended to XLEN.
- PID_W, 2, per-way pID width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- valid_i  in  1  IFU bundle valid.
- ready_o  out  1  bundle accepted when valid_i & ready_o.
- inst_i  in  WAYS*32  instructions; way k occupies [32k+31:32k].
- inst_addr_i  in  WAYS*32  per-way PC.
- pid_i  in  WAYS*PID_W  per-way pID.
- flush_i  in  1  discard held and in-flight state.
- ready_i  in  1  downstream ready.
- valid_o  out  1  output register valid.
- way_valid_o  out  WAYS  ways live in the current output segment.
- pid_o, inst_addr_o  out  as input  registered copies.
- opcode_o / funct3_o / funct7_o  out  WAYS*7 / WAYS*3 / WAYS*7  decoded fields.
- rs1_addr_o, rs2_addr_o, rd_addr_o  out  WAYS*5  register addresses.
- rs1_en_o, rs2_en_o, rd_we_o  out  WAYS  register enables.
- imm_o  out  WAYS*XLEN  immediate.
- shamt_o  out  WAYS*6  shift amount.
- illegal_o  out  WAYS  unknown-opcode flag.

Behaviour:
- Reset:
  - valid_o=0, way_valid_o=0, all registered fields=0.
  - State=IDLE; ready_o=1 in IDLE.
- Decode (combinational, per way), applied to opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM, OP-IMM-32, OP-32, AMO, OP-FP:
  - rs1_en: 0 for LUI/AUIPC/JAL. For SYSTEM, rs1_en=1 only when funct3!=0. 1 for the rest of the list.
  - rs2_en: 1 for BRANCH, STORE, OP, OP-32, AMO, OP-FP; 0 otherwise.
  - rd_we: 0 for BRANCH and STORE. For SYSTEM, rd_we=1 only when funct3!=0. 1 for the rest of the list.
  - rd_we is forced to 0 when rd=0.
  - JALR rd is taken from inst[11:7]; it is not hard-wired.
  - Disabled address fields read 0.
  - imm uses the I/S/B/U/J formats, sign-extended to XLEN; B and J get bit0=0.
  - shamt=inst[25:20] for OP-IMM with funct3 001/101; 0 otherwise.
  - Any other opcode: illegal=1, all enables=0.
- Hazard detection: way k (k>0) depends on way j<k when rd_we[j] and rd[j] equals an enabled rs1/rs2 of way k.
- State machine, states IDLE and SPLIT:
  - Register base = first way not yet issued.
  - On load, the segment is ways base..h-1, where h = the lowest dependent way index > base, or WAYS if there is none.
- IDLE:
  - Output register loads when its slot is free (!valid_o | ready_i) and valid_i.
  - If h==WAYS: full bundle loaded, ready_o=1, stay in IDLE.
  - Otherwise: latch the bundle internally, base=h, ready_o=0, go to SPLIT.
  - ready_o = slot free in IDLE.
- SPLIT:
  - ready_o=0.
  - When the slot is free, load the next segment.
  - When the segment reaches WAYS, return to IDLE; that cycle ready_o=slot free, so a new bundle may be accepted in the same cycle the last segment loads.
- Output register:
  - Holds stable while valid_o & !ready_i.
  - Clears valid_o when the slot is free and nothing is loaded.
  - Field registers of ways outside way_valid_o are 0.
- flush_i (highest priority):
  - Next cycle: valid_o=0, state=IDLE.
  - The input beat in the flush cycle is dropped.
  - ready_o=0 during the flush cycle.
- rst asserted mid-SPLIT: the latched bundle is discarded; the reset values above apply.
- Latency: 1 cycle from accepted bundle to valid_o. A split bundle needs 1 extra cycle per extra segment.

Optional Feature:
- Macro: DECODE_DEBUG_INST_EN.
- Defined: adds output port inst_o (WAYS*32), registered alongside the other fields and masked per way like them.
- Undefined: the port and its registers do not exist.
- Decode behaviour is identical in both cases.

Test Plan:
- Reset, then WAYS=2, bundle {0x00500093 addi x1,x0,5; 0x00A00113 addi x2,x0,10}, ready_i=1 -> next cycle:
  - valid_o=1, way_valid_o=2'b11.
  - imm way0=5, way1=10; rd 1/2; rd_we=2'b11; no stall.
- Bundle {addi x1,x0,5; 0x00108133 add x2,x1,x1} ->
  - Cycle 1: way_valid_o=2'b01, ready_o=0.
  - Cycle 2: way_valid_o=2'b10, rs1=rs2=1.
  - Then ready_o=1.
- ready_i=0 for 3 cycles with valid_o=1 -> outputs unchanged; ready_o=0; the following bundle is loaded only after ready_i returns to 1.
- Single-way bundle 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFF_FFFF_FFFF_FFFC, rd_we=0, rs2_en=1.
- flush_i pulsed during a SPLIT of the dependent bundle -> next cycle valid_o=0, state IDLE, second segment never emitted.
- Opcode 0x7F -> illegal_o=1, all enables=0. Separately, 0x00000073 (ecall) -> rs1_en=0, rd_we=0.

Source files
------------

// File: rtl/decode_stage_nway.sv
// decode_stage_nway: decodes a bundle of WAYS RISC-V instructions per cycle into a
// valid/ready output register. When a later way reads a register that an earlier way
// in the same bundle writes, the bundle is split and issued over several cycles.
// Optional build macro DECODE_DEBUG_INST_EN adds the registered raw-instruction
// output inst_o.
module decode_stage_nway #(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned XLEN  = 64,
  parameter int unsigned PID_W = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [WAYS*32-1:0]    inst_i,
  input  logic [WAYS*32-1:0]    inst_addr_i,
  input  logic [WAYS*PID_W-1:0] pid_i,
  input  logic                  flush_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [WAYS-1:0]       way_valid_o,
  output logic [WAYS*PID_W-1:0] pid_o,
  output logic [WAYS*32-1:0]    inst_addr_o,
`ifdef DECODE_DEBUG_INST_EN
  output logic [WAYS*32-1:0]    inst_o,
`endif
  output logic [WAYS*7-1:0]     opcode_o,
  output logic [WAYS*3-1:0]     funct3_o,
  output logic [WAYS*7-1:0]     funct7_o,
  output logic [WAYS*5-1:0]     rs1_addr_o,
  output logic [WAYS*5-1:0]     rs2_addr_o,
  output logic [WAYS*5-1:0]     rd_addr_o,
  output logic [WAYS-1:0]       rs1_en_o,
  output logic [WAYS-1:0]       rs2_en_o,
  output logic [WAYS-1:0]       rd_we_o,
  output logic [WAYS*XLEN-1:0]  imm_o,
  output logic [WAYS*6-1:0]     shamt_o,
  output logic [WAYS-1:0]       illegal_o
);

  localparam int          NWays = int'(WAYS);
  localparam int unsigned IdxW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StSplit = 1'b1;

  localparam logic [6:0] OpLui    = 7'h37;
  localparam logic [6:0] OpAuipc  = 7'h17;
  localparam logic [6:0] OpJal    = 7'h6f;
  localparam logic [6:0] OpJalr   = 7'h67;
  localparam logic [6:0] OpBranch = 7'h63;
  localparam logic [6:0] OpLoad   = 7'h03;
  localparam logic [6:0] OpStore  = 7'h23;
  localparam logic [6:0] OpOpImm  = 7'h13;
  localparam logic [6:0] OpOp     = 7'h33;
  localparam logic [6:0] OpSystem = 7'h73;
  localparam logic [6:0] OpImm32  = 7'h1b;
  localparam logic [6:0] OpOp32   = 7'h3b;
  localparam logic [6:0] OpAmo    = 7'h2f;
  localparam logic [6:0] OpOpFp   = 7'h53;

  // Control state and the bundle held while it is being split
  logic [0:0]                   state_q, state_d;
  logic [IdxW-1:0]              base_q, base_d;
  logic [WAYS-1:0][31:0]        bun_inst_q, bun_inst_d, bun_addr_q, bun_addr_d;
  logic [WAYS-1:0][PID_W-1:0]   bun_pid_q, bun_pid_d;

  // Output register
  logic                         valid_q, valid_d;
  logic [WAYS-1:0]              way_valid_q, way_valid_d;
  logic [WAYS-1:0][PID_W-1:0]   pid_q, pid_d;
  logic [WAYS-1:0][31:0]        addr_q, addr_d, oinst_q, oinst_d;
  logic [WAYS-1:0][6:0]         opcode_q, opcode_d, funct7_q, funct7_d;
  logic [WAYS-1:0][2:0]         funct3_q, funct3_d;
  logic [WAYS-1:0][4:0]         rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [WAYS-1:0]              rs1_en_q, rs1_en_d, rs2_en_q, rs2_en_d, rd_we_q, rd_we_d;
  logic [WAYS-1:0][XLEN-1:0]    imm_q, imm_d;
  logic [WAYS-1:0][5:0]         shamt_q, shamt_d;
  logic [WAYS-1:0]              illegal_q, illegal_d;

  // Decode results for every way of the current source bundle
  logic [WAYS-1:0][31:0]        src_inst, src_addr;
  logic [WAYS-1:0][PID_W-1:0]   src_pid;
  logic [WAYS-1:0][6:0]         dec_opcode, dec_funct7;
  logic [WAYS-1:0][2:0]         dec_funct3;
  logic [WAYS-1:0][4:0]         dec_rs1, dec_rs2, dec_rd;
  logic [WAYS-1:0]              dec_rs1_en, dec_rs2_en, dec_rd_we, dec_illegal;
  logic [WAYS-1:0][XLEN-1:0]    dec_imm;
  logic [WAYS-1:0][5:0]         dec_shamt;
  logic [31:0]                  cur, cur_imm;
  logic                         cur_r1, cur_r2, cur_wd, cur_ill;

  logic                         in_split, slot_free, load, dep;
  int                           base_int, h_int;
  logic [WAYS-1:0]              seg_mask;

  // Source bundle: live input while idle, latched copy while splitting
  always_comb begin
    in_split = (state_q == StSplit);
    src_inst = in_split ? bun_inst_q : inst_i;
    src_addr = in_split ? bun_addr_q : inst_addr_i;
    src_pid  = in_split ? bun_pid_q  : pid_i;
  end

  // Per-way field decode
  always_comb begin
    cur = '0; cur_imm = '0; cur_r1 = 1'b0; cur_r2 = 1'b0; cur_wd = 1'b0; cur_ill = 1'b0;
    dec_opcode = '0; dec_funct3 = '0; dec_funct7 = '0;
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    dec_rs1_en = '0; dec_rs2_en = '0; dec_rd_we = '0; dec_illegal = '0;
    dec_imm = '0; dec_shamt = '0;
    for (int k = 0; k < NWays; k++) begin
      cur     = src_inst[k];
      cur_imm = '0;
      cur_r1  = 1'b0;
      cur_r2  = 1'b0;
      cur_wd  = 1'b0;
      cur_ill = 1'b0;
      case (cur[6:0])
        OpLui, OpAuipc: begin
          cur_wd  = 1'b1;
          cur_imm = {cur[31:12], 12'b0};
        end
        OpJal: begin
          cur_wd  = 1'b1;
          cur_imm = {{12{cur[31]}}, cur[19:12], cur[20], cur[30:21], 1'b0};
        end
        OpJalr, OpLoad, OpOpImm, OpImm32: begin
          cur_r1  = 1'b1;
          cur_wd  = 1'b1;
          cur_imm = {{20{cur[31]}}, cur[31:20]};
        end
        OpBranch: begin
          cur_r1  = 1'b1;
          cur_r2  = 1'b1;
          cur_imm = {{20{cur[31]}}, cur[7], cur[30:25], cur[11:8], 1'b0};
        end
        OpStore: begin
          cur_r1  = 1'b1;
          cur_r2  = 1'b1;
          cur_imm = {{20{cur[31]}}, cur[31:25], cur[11:7]};
        end
        OpOp, OpOp32, OpAmo, OpOpFp: begin
          cur_r1 = 1'b1;
          cur_r2 = 1'b1;
          cur_wd = 1'b1;
        end
        OpSystem: begin
          // ecall/ebreak (funct3==0) touch no GPRs; CSR ops read rs1 and write rd
          cur_r1  = (cur[14:12] != 3'b000);
          cur_wd  = (cur[14:12] != 3'b000);
          cur_imm = {{20{cur[31]}}, cur[31:20]};
        end
        default: cur_ill = 1'b1;
      endcase
      cur_wd = cur_wd && (cur[11:7] != 5'd0);

      dec_opcode[k]  = cur[6:0];
      dec_funct3[k]  = cur[14:12];
      dec_funct7[k]  = cur[31:25];
      dec_rs1_en[k]  = cur_r1;
      dec_rs2_en[k]  = cur_r2;
      dec_rd_we[k]   = cur_wd;
      dec_illegal[k] = cur_ill;
      dec_rs1[k]     = cur_r1 ? cur[19:15] : 5'd0;
      dec_rs2[k]     = cur_r2 ? cur[24:20] : 5'd0;
      dec_rd[k]      = cur_wd ? cur[11:7]  : 5'd0;
      dec_imm[k]     = XLEN'(signed'(cur_imm));
      dec_shamt[k]   = ((cur[6:0] == OpOpImm) && (cur[13:12] == 2'b01)) ? cur[25:20] : 6'd0;
    end
  end

  // Segment end h: first way after base reading a register written earlier in the segment
  always_comb begin
    base_int = in_split ? int'(base_q) : 0;
    h_int    = NWays;
    dep      = 1'b0;
    for (int k = NWays - 1; k >= 1; k--) begin
      dep = 1'b0;
      for (int j = 0; j < k; j++) begin
        if ((j >= base_int) && dec_rd_we[j] &&
            ((dec_rs1_en[k] && (dec_rd[j] == dec_rs1[k])) ||
             (dec_rs2_en[k] && (dec_rd[j] == dec_rs2[k])))) begin
          dep = 1'b1;
        end
      end
      if ((k > base_int) && dep) h_int = k;
    end
    for (int k = 0; k < NWays; k++) seg_mask[k] = (k >= base_int) && (k < h_int);
  end

  // Handshake and FSM next state
  always_comb begin
    slot_free  = !valid_q || ready_i;
    load       = !flush_i && slot_free && (in_split || valid_i);
    ready_o    = !flush_i && !in_split && slot_free;
    state_d    = state_q;
    base_d     = base_q;
    bun_inst_d = bun_inst_q;
    bun_addr_d = bun_addr_q;
    bun_pid_d  = bun_pid_q;
    if (flush_i) begin
      state_d = StIdle;
      base_d  = '0;
    end else if (load) begin
      if (h_int == NWays) begin
        state_d = StIdle;
        base_d  = '0;
      end else begin
        state_d = StSplit;
        base_d  = IdxW'(h_int);
        if (!in_split) begin
          bun_inst_d = src_inst;
          bun_addr_d = src_addr;
          bun_pid_d  = src_pid;
        end
      end
    end
  end

  // Output register: load masked segment, clear when drained or flushed, else hold
  always_comb begin
    valid_d = valid_q; way_valid_d = way_valid_q; pid_d = pid_q; addr_d = addr_q;
    oinst_d = oinst_q; opcode_d = opcode_q; funct3_d = funct3_q; funct7_d = funct7_q;
    rs1_d = rs1_q; rs2_d = rs2_q; rd_d = rd_q; rs1_en_d = rs1_en_q; rs2_en_d = rs2_en_q;
    rd_we_d = rd_we_q; imm_d = imm_q; shamt_d = shamt_q; illegal_d = illegal_q;
    if (load) begin
      valid_d     = 1'b1;
      way_valid_d = seg_mask;
      for (int k = 0; k < NWays; k++) begin
        pid_d[k]     = seg_mask[k] ? src_pid[k]     : '0;
        addr_d[k]    = seg_mask[k] ? src_addr[k]    : '0;
        oinst_d[k]   = seg_mask[k] ? src_inst[k]    : '0;
        opcode_d[k]  = seg_mask[k] ? dec_opcode[k]  : '0;
        funct3_d[k]  = seg_mask[k] ? dec_funct3[k]  : '0;
        funct7_d[k]  = seg_mask[k] ? dec_funct7[k]  : '0;
        rs1_d[k]     = seg_mask[k] ? dec_rs1[k]     : '0;
        rs2_d[k]     = seg_mask[k] ? dec_rs2[k]     : '0;
        rd_d[k]      = seg_mask[k] ? dec_rd[k]      : '0;
        rs1_en_d[k]  = seg_mask[k] && dec_rs1_en[k];
        rs2_en_d[k]  = seg_mask[k] && dec_rs2_en[k];
        rd_we_d[k]   = seg_mask[k] && dec_rd_we[k];
        imm_d[k]     = seg_mask[k] ? dec_imm[k]     : '0;
        shamt_d[k]   = seg_mask[k] ? dec_shamt[k]   : '0;
        illegal_d[k] = seg_mask[k] && dec_illegal[k];
      end
    end else if (flush_i || slot_free) begin
      valid_d = 1'b0; way_valid_d = '0; pid_d = '0; addr_d = '0; oinst_d = '0;
      opcode_d = '0; funct3_d = '0; funct7_d = '0; rs1_d = '0; rs2_d = '0; rd_d = '0;
      rs1_en_d = '0; rs2_en_d = '0; rd_we_d = '0; imm_d = '0; shamt_d = '0; illegal_d = '0;
    end
  end

  // State update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle; base_q <= '0;
      bun_inst_q <= '0; bun_addr_q <= '0; bun_pid_q <= '0;
      valid_q <= 1'b0; way_valid_q <= '0; pid_q <= '0; addr_q <= '0; oinst_q <= '0;
      opcode_q <= '0; funct3_q <= '0; funct7_q <= '0; rs1_q <= '0; rs2_q <= '0; rd_q <= '0;
      rs1_en_q <= '0; rs2_en_q <= '0; rd_we_q <= '0; imm_q <= '0; shamt_q <= '0;
      illegal_q <= '0;
    end else begin
      state_q <= state_d; base_q <= base_d;
      bun_inst_q <= bun_inst_d; bun_addr_q <= bun_addr_d; bun_pid_q <= bun_pid_d;
      valid_q <= valid_d; way_valid_q <= way_valid_d; pid_q <= pid_d; addr_q <= addr_d;
      oinst_q <= oinst_d; opcode_q <= opcode_d; funct3_q <= funct3_d; funct7_q <= funct7_d;
      rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q <= rd_d; rs1_en_q <= rs1_en_d;
      rs2_en_q <= rs2_en_d; rd_we_q <= rd_we_d; imm_q <= imm_d; shamt_q <= shamt_d;
      illegal_q <= illegal_d;
    end
  end

  assign valid_o     = valid_q;
  assign way_valid_o = way_valid_q;
  assign pid_o       = pid_q;
  assign inst_addr_o = addr_q;
  assign opcode_o    = opcode_q;
  assign funct3_o    = funct3_q;
  assign funct7_o    = funct7_q;
  assign rs1_addr_o  = rs1_q;
  assign rs2_addr_o  = rs2_q;
  assign rd_addr_o   = rd_q;
  assign rs1_en_o    = rs1_en_q;
  assign rs2_en_o    = rs2_en_q;
  assign rd_we_o     = rd_we_q;
  assign imm_o       = imm_q;
  assign shamt_o     = shamt_q;
  assign illegal_o   = illegal_q;
`ifdef DECODE_DEBUG_INST_EN
  assign inst_o      = oinst_q;
`else
  // Raw-instruction register has no consumer without the debug port
  logic unused_oinst;
  assign unused_oinst = ^oinst_q;
`endif

endmodule

// File: tb/tb_decode_stage_nway.sv
// Directed self-checking bench for decode_stage_nway with WAYS=2, XLEN=64.
module tb_decode_stage_nway;

  localparam int W = 2;
  localparam int X = 64;
  localparam int P = 2;

  logic           clk = 1'b0;
  logic           rst, valid_i, ready_o, flush_i, ready_i, valid_o;
  logic [W*32-1:0] inst_i, inst_addr_i, inst_addr_o;
  logic [W*P-1:0]  pid_i, pid_o;
  logic [W-1:0]    way_valid_o, rs1_en_o, rs2_en_o, rd_we_o, illegal_o;
  logic [W*7-1:0]  opcode_o, funct7_o;
  logic [W*3-1:0]  funct3_o;
  logic [W*5-1:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [W*X-1:0]  imm_o;
  logic [W*6-1:0]  shamt_o;
`ifdef DECODE_DEBUG_INST_EN
  logic [W*32-1:0] inst_o;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_stage_nway #(.WAYS(W), .XLEN(X), .PID_W(P)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i), .pid_i(pid_i),
    .flush_i(flush_i), .ready_i(ready_i), .valid_o(valid_o),
    .way_valid_o(way_valid_o), .pid_o(pid_o), .inst_addr_o(inst_addr_o),
`ifdef DECODE_DEBUG_INST_EN
    .inst_o(inst_o),
`endif
    .opcode_o(opcode_o), .funct3_o(funct3_o), .funct7_o(funct7_o),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o),
    .rs1_en_o(rs1_en_o), .rs2_en_o(rs2_en_o), .rd_we_o(rd_we_o),
    .imm_o(imm_o), .shamt_o(shamt_o), .illegal_o(illegal_o)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i0, input logic [31:0] i1);
    valid_i     = 1'b1;
    inst_i      = {i1, i0};
    inst_addr_i = {32'h104, 32'h100};
    pid_i       = {2'd2, 2'd1};
  endtask

  localparam logic [31:0] AddiX1 = 32'h0050_0093;  // addi x1,x0,5
  localparam logic [31:0] AddiX2 = 32'h00A0_0113;  // addi x2,x0,10
  localparam logic [31:0] AddX2  = 32'h0010_8133;  // add x2,x1,x1

  initial begin
    rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    inst_i = '0; inst_addr_i = '0; pid_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_way_valid", way_valid_o, 0);
    check_eq("rst_imm", imm_o, 0);
    check_eq("rst_rd", rd_addr_o, 0);
    check_eq("rst_ready", ready_o, 1);

    // Independent bundle
    cyc(); rst = 1'b0; drive(AddiX1, AddiX2);
    @(negedge clk); check_eq("ind_ready", ready_o, 1);
    cyc(); valid_i = 1'b0;
    @(negedge clk);
    check_eq("ind_valid", valid_o, 1);
    check_eq("ind_way_valid", way_valid_o, 2'b11);
    check_eq("ind_imm0", imm_o[63:0], 5);
    check_eq("ind_imm1", imm_o[127:64], 10);
    check_eq("ind_rd", rd_addr_o, 10'h041);
    check_eq("ind_rd_we", rd_we_o, 2'b11);
    check_eq("ind_rs2_en", rs2_en_o, 2'b00);
    check_eq("ind_pid", pid_o, 4'b1001);
    check_eq("ind_addr", inst_addr_o, {32'h104, 32'h100});
    check_eq("ind_ready2", ready_o, 1);
    cyc();
    @(negedge clk); check_eq("drain_valid", valid_o, 0);

    // Dependent bundle splits in two
    cyc(); drive(AddiX1, AddX2);
    @(negedge clk); check_eq("dep_accept", ready_o, 1);
    cyc(); valid_i = 1'b0;
    @(negedge clk);
    check_eq("dep1_way_valid", way_valid_o, 2'b01);
    check_eq("dep1_ready", ready_o, 0);
    check_eq("dep1_rd", rd_addr_o, 10'h001);
    check_eq("dep1_imm1_masked", imm_o[127:64], 0);
    cyc();
    @(negedge clk);
    check_eq("dep2_way_valid", way_valid_o, 2'b10);
    check_eq("dep2_rs1", rs1_addr_o, 10'h020);
    check_eq("dep2_rs2", rs2_addr_o, 10'h020);
    check_eq("dep2_rs_en", {rs1_en_o, rs2_en_o}, 4'b1010);
    check_eq("dep2_rd", rd_addr_o, 10'h040);
    check_eq("dep2_pid", pid_o, 4'b1000);
    check_eq("dep2_ready", ready_o, 1);

    // Back-pressure: held output, next bundle only after ready_i returns
    cyc(); drive(32'h0030_0193, 32'h0070_0213);
    @(negedge clk); check_eq("bp_accept", ready_o, 1);
    cyc(); ready_i = 1'b0; drive(32'h00B0_0293, 32'h00C0_0313);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("bp_hold_valid", valid_o, 1);
      check_eq("bp_hold_imm", imm_o[63:0], 3);
      check_eq("bp_hold_rd", rd_addr_o, 10'h083);
      check_eq("bp_ready", ready_o, 0);
      if (i < 2) cyc();
    end
    cyc(); ready_i = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", ready_o, 1);
    check_eq("bp_release_imm", imm_o[63:0], 3);
    cyc(); valid_i = 1'b0;
    @(negedge clk);
    check_eq("bp_next_imm", imm_o, {64'd12, 64'd11});
    check_eq("bp_next_rd", rd_addr_o, 10'h0C5);

    // Branch with negative B immediate, plus nop
    cyc(); drive(32'hFE00_0EE3, 32'h0000_0013);
    cyc(); valid_i = 1'b0;
    @(negedge clk);
    check_eq("beq_imm", imm_o[63:0], 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("beq_rd_we", rd_we_o, 2'b00);
    check_eq("beq_rs2_en", rs2_en_o, 2'b01);
    check_eq("beq_way_valid", way_valid_o, 2'b11);

    // Negative LUI and slli shamt
    cyc(); drive(32'hFFFF_F437, 32'h0210_9393);
    cyc(); valid_i = 1'b0;
    @(negedge clk);
    check_eq("lui_imm", imm_o[63:0], 64'hFFFF_FFFF_FFFF_F000);
    check_eq("slli_imm", imm_o[127:64], 64'd33);
    check_eq("slli_shamt", shamt_o, 12'h840);
    check_eq("lui_slli_rs1", rs1_addr_o, 10'h020);
    check_eq("lui_slli_rd_we", rd_we_o, 2'b11);

    // Illegal opcode and ecall
    cyc(); drive(32'h0000_007F, 32'h0000_0073);
    cyc(); valid_i = 1'b0;
    @(negedge clk);
    check_eq("ill_flag", illegal_o, 2'b01);
    check_eq("ill_en", {rs1_en_o, rs2_en_o, rd_we_o}, 6'b0);
    check_eq("ill_opcode", opcode_o, 14'h39FF);

    // Flush during split drops the second segment
    cyc(); drive(AddiX1, AddX2);
    cyc(); valid_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    check_eq("fl_seg1", way_valid_o, 2'b01);
    check_eq("fl_ready", ready_o, 0);
    cyc(); flush_i = 1'b0;
    @(negedge clk);
    check_eq("fl_valid", valid_o, 0);
    check_eq("fl_idle_ready", ready_o, 1);
    cyc();
    @(negedge clk); check_eq("fl_no_seg2", valid_o, 0);

    // Reset during split discards the latched bundle
    cyc(); drive(AddiX1, AddX2);
    cyc(); valid_i = 1'b0; rst = 1'b1;
    @(negedge clk); check_eq("rs_seg1", way_valid_o, 2'b01);
    cyc(); rst = 1'b0;
    @(negedge clk);
    check_eq("rs_valid", valid_o, 0);
    check_eq("rs_ready", ready_o, 1);
    cyc();
    @(negedge clk); check_eq("rs_no_seg2", valid_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
